// File: rtl/data_ram_responder.sv
// Multi-cycle MEM-stage data RAM: byte/half/word big-endian loads and stores
// executed after a fixed wait, with a one-cycle completion pulse and pipeline stall.
module data_ram_responder #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  RAM_Enable,
    input  logic                  RAM_RW,
    input  logic                  RAM_SE,
    input  logic [1:0]            RAM_Size,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MOC,
    output logic                  Misaligned,
    output logic                  Stall
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [7:0]            r_mem [0:DEPTH-1];
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_rw;
    logic                  r_se;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_din;

    logic [ADDR_WIDTH-1:0] w_a1;
    logic [ADDR_WIDTH-1:0] w_a2;
    logic [ADDR_WIDTH-1:0] w_a3;
    logic [7:0]            w_b0;
    logic [7:0]            w_b1;
    logic [7:0]            w_b2;
    logic [7:0]            w_b3;
    logic                  w_is_word;
    logic                  w_is_half;
    logic                  w_misaligned;
    logic                  w_exec;
    logic                  w_wr_en;
    logic [31:0]           w_load_data;

    assign w_a1 = r_addr + ADDR_WIDTH'(1);
    assign w_a2 = r_addr + ADDR_WIDTH'(2);
    assign w_a3 = r_addr + ADDR_WIDTH'(3);
    assign w_b0 = r_mem[r_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    // Size 11 is handled as a word everywhere.
    assign w_is_word    = r_size[1];
    assign w_is_half    = (r_size == 2'b01);
    assign w_misaligned = (w_is_word && (r_addr[1:0] != 2'b00)) || (w_is_half && r_addr[0]);
    assign w_exec       = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_wr_en      = w_exec && r_rw && !w_misaligned;

    assign Stall = RAM_Enable && (r_state != S_DONE);

    // Load result with size-dependent sign/zero extension.
    always_comb begin
        w_load_data = 32'd0;
        if (w_is_word) begin
            w_load_data = {w_b0, w_b1, w_b2, w_b3};
        end else if (w_is_half) begin
            w_load_data = {{16{r_se & w_b0[7]}}, w_b0, w_b1};
        end else begin
            w_load_data = {{24{r_se & w_b0[7]}}, w_b0};
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (w_is_word) begin
                r_mem[r_addr] <= r_din[31:24];
                r_mem[w_a1]   <= r_din[23:16];
                r_mem[w_a2]   <= r_din[15:8];
                r_mem[w_a3]   <= r_din[7:0];
            end else if (w_is_half) begin
                r_mem[r_addr] <= r_din[15:8];
                r_mem[w_a1]   <= r_din[7:0];
            end else begin
                r_mem[r_addr] <= r_din[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rw       <= 1'b0;
            r_se       <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_din      <= 32'd0;
            DataOut    <= 32'd0;
            MOC        <= 1'b0;
            Misaligned <= 1'b0;
        end else begin
            MOC        <= 1'b0;
            Misaligned <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (RAM_Enable) begin
                        r_rw    <= RAM_RW;
                        r_se    <= RAM_SE;
                        r_size  <= RAM_Size;
                        r_addr  <= Address;
                        r_din   <= DataIn;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        MOC        <= 1'b1;
                        Misaligned <= w_misaligned;
                        if (w_misaligned) begin
                            DataOut <= 32'd0;
                        end else if (!r_rw) begin
                            DataOut <= w_load_data;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: timing, load extension, stores,
// misalignment, reset abort and back-to-back requests.
module tb_data_ram_responder;

    localparam int unsigned ADDR_WIDTH = 9;
    localparam int unsigned LATENCY    = 2;

    logic                  clk;
    logic                  Reset;
    logic                  RAM_Enable;
    logic                  RAM_RW;
    logic                  RAM_SE;
    logic [1:0]            RAM_Size;
    logic [ADDR_WIDTH-1:0] Address;
    logic [31:0]           DataIn;
    logic [31:0]           DataOut;
    logic                  MOC;
    logic                  Misaligned;
    logic                  Stall;

    int n_checks;
    int n_fail;

    data_ram_responder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .RAM_Enable(RAM_Enable),
        .RAM_RW    (RAM_RW),
        .RAM_SE    (RAM_SE),
        .RAM_Size  (RAM_Size),
        .Address   (Address),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .MOC       (MOC),
        .Misaligned(Misaligned),
        .Stall     (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return {dut.r_mem[a], dut.r_mem[a+1], dut.r_mem[a+2], dut.r_mem[a+3]};
    endfunction

    // One full request; called and returns #1 after a rising edge.
    task automatic do_access(input string tag, input logic rw, input logic se,
                             input logic [1:0] size, input logic [ADDR_WIDTH-1:0] addr,
                             input logic [31:0] din,
                             output logic [31:0] dout, output logic mis);
        int  k;
        logic seen;
        RAM_Enable = 1'b1;
        RAM_RW     = rw;
        RAM_SE     = se;
        RAM_Size   = size;
        Address    = addr;
        DataIn     = din;
        #1;
        check_eq({tag, " stall_req"}, 32'(Stall), 32'd1);
        seen = 1'b0;
        k    = 0;
        dout = 32'd0;
        mis  = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (MOC) seen = 1'b1;
        end
        check_eq({tag, " latency"}, 32'(k), 32'(LATENCY + 1));
        check_eq({tag, " stall_moc"}, 32'(Stall), 32'd0);
        dout = DataOut;
        mis  = Misaligned;
        RAM_Enable = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, " moc_fall"}, 32'(MOC), 32'd0);
    endtask

    initial begin
        logic [31:0] dout;
        logic        mis;
        logic        moc_seen;
        int          n_moc;
        int          moc_k [2];
        logic [31:0] moc_d [2];

        n_checks   = 0;
        n_fail     = 0;
        Reset      = 1'b1;
        RAM_Enable = 1'b0;
        RAM_RW     = 1'b0;
        RAM_SE     = 1'b0;
        RAM_Size   = 2'b00;
        Address    = '0;
        DataIn     = 32'd0;

        dut.r_mem[0]  = 8'hDE; dut.r_mem[1]  = 8'hAD; dut.r_mem[2]  = 8'hBE; dut.r_mem[3]  = 8'hEF;
        dut.r_mem[4]  = 8'h44; dut.r_mem[5]  = 8'h55; dut.r_mem[6]  = 8'h66; dut.r_mem[7]  = 8'h77;
        dut.r_mem[8]  = 8'hA0; dut.r_mem[9]  = 8'hA1; dut.r_mem[10] = 8'hA2; dut.r_mem[11] = 8'hA3;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst DataOut", DataOut, 32'd0);
        check_eq("rst MOC", 32'(MOC), 32'd0);
        check_eq("rst Misaligned", 32'(Misaligned), 32'd0);
        check_eq("rst Stall", 32'(Stall), 32'd0);
        Reset = 1'b0;
        @(posedge clk);
        #1;

        // Loads with extension variants
        do_access("lw0", 1'b0, 1'b0, 2'b10, 9'd0, 32'd0, dout, mis);
        check_eq("lw0 data", dout, 32'hDEADBEEF);
        check_eq("lw0 mis", 32'(mis), 32'd0);
        do_access("lb0s", 1'b0, 1'b1, 2'b00, 9'd0, 32'd0, dout, mis);
        check_eq("lb0s data", dout, 32'hFFFFFFDE);
        do_access("lb0u", 1'b0, 1'b0, 2'b00, 9'd0, 32'd0, dout, mis);
        check_eq("lb0u data", dout, 32'h000000DE);
        do_access("lh2s", 1'b0, 1'b1, 2'b01, 9'd2, 32'd0, dout, mis);
        check_eq("lh2s data", dout, 32'hFFFFBEEF);
        do_access("lb5u", 1'b0, 1'b0, 2'b00, 9'd5, 32'd0, dout, mis);
        check_eq("lb5u data", dout, 32'h00000055);
        check_eq("lb5u mis", 32'(mis), 32'd0);
        do_access("l11_4", 1'b0, 1'b1, 2'b11, 9'd4, 32'd0, dout, mis);
        check_eq("l11_4 data", dout, 32'h44556677);

        // Halfword store then word readback
        do_access("sh8", 1'b1, 1'b0, 2'b01, 9'd8, 32'h12345678, dout, mis);
        check_eq("sh8 dout_kept", dout, 32'h44556677);
        check_eq("sh8 mem", mem_word(8), 32'h5678A2A3);
        do_access("lw8", 1'b0, 1'b0, 2'b10, 9'd8, 32'd0, dout, mis);
        check_eq("lw8 data", dout, 32'h5678A2A3);

        // Misaligned accesses
        do_access("sw6", 1'b1, 1'b0, 2'b10, 9'd6, 32'h11223344, dout, mis);
        check_eq("sw6 mis", 32'(mis), 32'd1);
        check_eq("sw6 data", dout, 32'd0);
        check_eq("sw6 mem", mem_word(6), 32'h66775678);
        do_access("lw0b", 1'b0, 1'b0, 2'b10, 9'd0, 32'd0, dout, mis);
        do_access("lh5", 1'b0, 1'b1, 2'b01, 9'd5, 32'd0, dout, mis);
        check_eq("lh5 mis", 32'(mis), 32'd1);
        check_eq("lh5 data", dout, 32'd0);

        // Store aborted by reset during the wait
        do_access("lw0c", 1'b0, 1'b0, 2'b10, 9'd0, 32'd0, dout, mis);
        RAM_Enable = 1'b1;
        RAM_RW     = 1'b1;
        RAM_Size   = 2'b10;
        Address    = 9'd0;
        DataIn     = 32'hCAFEBABE;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        Reset      = 1'b1;
        RAM_Enable = 1'b0;
        #1;
        check_eq("abort moc", 32'(MOC), 32'd0);
        check_eq("abort dout_rst", DataOut, 32'd0);
        moc_seen = 1'b0;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            moc_seen |= MOC;
        end
        check_eq("abort no_moc", 32'(moc_seen), 32'd0);
        check_eq("abort mem", mem_word(0), 32'hDEADBEEF);
        do_access("lw0d", 1'b0, 1'b0, 2'b10, 9'd0, 32'd0, dout, mis);
        check_eq("lw0d data", dout, 32'hDEADBEEF);

        // Back-to-back loads with RAM_Enable held
        n_moc      = 0;
        moc_k[0]   = 0;
        moc_k[1]   = 0;
        moc_d[0]   = 32'd0;
        moc_d[1]   = 32'd0;
        RAM_Enable = 1'b1;
        RAM_RW     = 1'b0;
        RAM_SE     = 1'b0;
        RAM_Size   = 2'b10;
        Address    = 9'd0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) check_eq("b2b stall_idle", 32'(Stall), 32'd1);
            if (MOC) begin
                if (n_moc < 2) begin
                    moc_k[n_moc] = k;
                    moc_d[n_moc] = DataOut;
                end
                n_moc++;
                Address = 9'd8;
                if (n_moc >= 2) RAM_Enable = 1'b0;
            end
        end
        check_eq("b2b count", 32'(n_moc), 32'd2);
        check_eq("b2b first_k", 32'(moc_k[0]), 32'd3);
        check_eq("b2b second_k", 32'(moc_k[1]), 32'd7);
        check_eq("b2b first_d", moc_d[0], 32'hDEADBEEF);
        check_eq("b2b second_d", moc_d[1], 32'h5678A2A3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

- Multi-cycle data-memory responder for the MEM stage of the RISC-V pipeline.
- Consumes the MEM-stage RAM control bundle (RAM_Enable, RAM_RW, RAM_SE, RAM_Size), plus address and store data from the datapath.
- Performs byte, halfword and word loads and stores after a programmable wait, returning load data and a one-cycle completion pulse.
- Drives the Stall line; stall/hazard logic uses it to drop PC/IF_ID LE and select the NOP path of the control-unit multiplexer.

## Interface
- ADDR_WIDTH, 9, byte-address width; the array is 2**ADDR_WIDTH bytes.
- LATENCY, 2, wait cycles before the access executes; legal range 1..15.
- clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- RAM_Enable  input  1  request valid; the requester holds it and all request inputs stable until the cycle MOC is high.
- RAM_RW  input  1  0 = load, 1 = store.
- RAM_SE  input  1  load sign-extend (1) / zero-extend (0).
- RAM_Size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- Address  input  ADDR_WIDTH  byte address.
- DataIn  input  32  store data, right-justified.
- DataOut  output  32  load result; registered, held until the next completed load.
- MOC  output  1  memory-operation-complete, one-cycle pulse.
- Misaligned  output  1  high together with MOC when the access was misaligned.
- Stall  output  1  combinational: RAM_Enable & (state != DONE).

## Operation
- Storage is a byte array `Mem[0:2**ADDR_WIDTH-1]`.
- `Mem` is not cleared by Reset; benches preload it hierarchically.
- Byte order is big-endian: `Mem[A]` holds the most significant byte of a word or halfword.
- FSM states are IDLE, WAIT and DONE, with a 4-bit down-counter `cnt`.
- IDLE:
  - If RAM_Enable=1 at the edge: latch the request, set cnt=LATENCY-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt≠0: cnt←cnt-1.
  - If cnt==0: execute the access at this edge, set MOC=1, go to DONE.
- DONE: clear MOC and Misaligned, go to IDLE unconditionally.
  - RAM_Enable still high in DONE belongs to the completed request and is not re-sampled.
- Alignment:
  - Word requires Address[1:0]=00; halfword requires Address[0]=0.
  - A misaligned access does not write, DataOut←0, Misaligned=1 with MOC.
- Loads:
  - Byte: sign-extends from bit 7 if RAM_SE=1, else zero-extends.
  - Halfword: sign-extends from bit 15 if RAM_SE=1, else zero-extends.
  - Word: RAM_SE is ignored.
- Stores:
  - Byte writes DataIn[7:0] to `Mem[A]`.
  - Halfword writes `Mem[A]`=DataIn[15:8], `Mem[A+1]`=DataIn[7:0].
  - Word writes DataIn[31:24]..DataIn[7:0] to `Mem[A]`..`Mem[A+3]`.
  - DataOut is unchanged by stores.
- Request inputs are sampled only at the IDLE→WAIT edge; changes during WAIT are ignored.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, cnt=0, DataOut=0, MOC=0, Misaligned=0.
- Stall follows RAM_Enable combinationally.
- Request first seen at edge E0:
  - Access executes and MOC rises at edge E0+LATENCY.
  - MOC falls at edge E0+LATENCY+1.
  - RAM_Enable is held for LATENCY+1 cycles.
  - Stall is high for the first LATENCY cycles and low in the MOC cycle, so the pipeline advances at the edge that ends the MOC cycle.
- Back-to-back requests: a new RAM_Enable is sampled no earlier than the edge after DONE, which gives at least one IDLE cycle between accesses.
- Reset asserted during WAIT: the request is aborted and no memory write occurs. After Reset deasserts, a still-asserted RAM_Enable starts a fresh access.
- Reset asserted in the MOC cycle: MOC drops immediately. The store has already been committed.
- LATENCY=1 gives the minimum 2-cycle access.

## Test plan
- Reset, then with LATENCY=2 preload `Mem[0..3]`=DE AD BE EF and issue a word load at address 0 -> Stall high for 2 cycles; MOC pulses exactly one cycle at E0+2; DataOut=DEADBEEF; Misaligned=0.
- Byte load at address 0, RAM_SE=1 -> DataOut=FFFFFFDE. With RAM_SE=0 -> 000000DE. Halfword load at address 2, RAM_SE=1 -> FFFFBEEF.
- Halfword store DataIn=12345678 at address 8, then word load at address 8 -> `Mem[8]`=56, `Mem[9]`=78, untouched bytes kept; DataOut reflects 5678 in the upper half.
- Word store at address 6 -> Misaligned=1 with MOC; `Mem[6..9]` unchanged; DataOut=0.
- Store issued, Reset pulsed one cycle after E0 -> MOC never rises and memory is unchanged. A reissued load returns the old data.
- Two consecutive loads with RAM_Enable held continuously -> exactly two MOC pulses, separated by an IDLE cycle; DataOut updates on each MOC.
